// File: rtl/servant_rst_pkg.sv
// -----------------------------------------------------------------------------
// servant_rst_pkg
// Shared types and constants for the servant reset sequencer.
//   rst_state_e  : sequencer state (PULSE, WAIT_LOCK, STABLE, RUN), 2-bit code
//   LOST_CNT_W   : width of the loss-of-lock debug counter
//   lost_sat_inc : saturating increment used for that counter
// -----------------------------------------------------------------------------
package servant_rst_pkg;

  typedef enum logic [1:0] {
    PULSE     = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } rst_state_e;

  localparam int LOST_CNT_W = 8;
  localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = '1;

  // Holds at all-ones instead of wrapping so a long-running board still
  // shows "many losses" rather than a misleadingly small number.
  function automatic logic [LOST_CNT_W-1:0] lost_sat_inc(input logic [LOST_CNT_W-1:0] v);
    return (v == LOST_CNT_MAX) ? v : v + LOST_CNT_W'(1);
  endfunction

endpackage

// File: rtl/servant_rst_seq_if.sv
// -----------------------------------------------------------------------------
// servant_rst_seq_if
// Signal bundle between the board-level PLL/SoC glue and the reset sequencer.
//   pll_lock  : PLL locked flag (asynchronous to sys_clk)
//   heartbeat : SoC activity signal, any edge counts
//   sys_rst   : active-high SoC reset
//   sys_rst_n : complement of sys_rst
//   stdy_rst  : USR_LOCKED_STDY_RST drive
//   ready     : high only while the SoC runs
//   lost_cnt  : saturating count of accepted lock losses
// Modports: master = board/SoC side, slave = sequencer.
// -----------------------------------------------------------------------------
interface servant_rst_seq_if;
  import servant_rst_pkg::*;

  logic                  pll_lock;
  logic                  heartbeat;
  logic                  sys_rst;
  logic                  sys_rst_n;
  logic                  stdy_rst;
  logic                  ready;
  logic [LOST_CNT_W-1:0] lost_cnt;

  modport master (
    output pll_lock, heartbeat,
    input  sys_rst, sys_rst_n, stdy_rst, ready, lost_cnt
  );

  modport slave (
    input  pll_lock, heartbeat,
    output sys_rst, sys_rst_n, stdy_rst, ready, lost_cnt
  );
endinterface

// File: rtl/servant_sync2.sv
// -----------------------------------------------------------------------------
// servant_sync2
// Two-flop synchroniser, one independent chain per bit, async active-low clear.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low clear
//   i_d     : asynchronous input bits
//   o_q     : synchronised bits, two i_clk cycles behind i_d
// -----------------------------------------------------------------------------
module servant_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_meta[gi] <= 1'b0;
          r_sync[gi] <= 1'b0;
        end else begin
          r_meta[gi] <= i_d[gi];
          r_sync[gi] <= r_meta[gi];
        end
      end
    end
  endgenerate

  assign o_q = r_sync;

endmodule

// File: rtl/servant_rst_seq.sv
// -----------------------------------------------------------------------------
// servant_rst_seq
// Reset sequencer between CC_PLL / CC_USR_RSTN and the servant SoC. Holds the
// SoC in reset until the synchronised PLL lock has stayed high long enough,
// filters short lock drops in RUN and re-sequences on a real loss of lock.
//   sys_clk  : system clock (PLL CLK0)
//   usr_rstn : asynchronous active-low reset (CC_USR_RSTN)
//   bus      : servant_rst_seq_if.slave (pll_lock, heartbeat in;
//              sys_rst, sys_rst_n, stdy_rst, ready, lost_cnt out)
// Optional build macro SERVANT_RST_WDT_EN adds a heartbeat watchdog in RUN;
// without it the heartbeat input is ignored.
// -----------------------------------------------------------------------------
module servant_rst_seq
  import servant_rst_pkg::*;
#(
  parameter int STABLE_CYCLES   = 16,
  parameter int DROP_FILTER     = 4,
  parameter int STDY_RST_CYCLES = 8,
  parameter int WDT_CYCLES      = 16777216
) (
  input  logic             sys_clk,
  input  logic             usr_rstn,
  servant_rst_seq_if.slave bus
);

  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int DRP_W = $clog2(DROP_FILTER + 1);
  localparam int PLS_W = $clog2(STDY_RST_CYCLES + 1);

  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_CYCLES);
  localparam logic [DRP_W-1:0] DRP_LAST = DRP_W'(DROP_FILTER - 1);
  localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(STDY_RST_CYCLES - 1);

  rst_state_e            r_state;
  logic [STB_W-1:0]      r_stable_cnt;
  logic [DRP_W-1:0]      r_drop_cnt;
  logic [PLS_W-1:0]      r_pulse_cnt;
  logic                  r_sys_rst;
  logic                  r_stdy_rst;
  logic                  r_ready;
  logic [LOST_CNT_W-1:0] r_lost_cnt;
  logic                  w_lock_s;

  servant_sync2 #(.WIDTH(1)) u_lock_sync (
    .i_clk   (sys_clk),
    .i_rst_n (usr_rstn),
    .i_d     (bus.pll_lock),
    .o_q     (w_lock_s)
  );

`ifdef SERVANT_RST_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] r_wdt_cnt;
  logic             r_hb_prev;
  logic             w_hb_s;
  logic             w_hb_edge;

  servant_sync2 #(.WIDTH(1)) u_hb_sync (
    .i_clk   (sys_clk),
    .i_rst_n (usr_rstn),
    .i_d     (bus.heartbeat),
    .o_q     (w_hb_s)
  );

  assign w_hb_edge = w_hb_s ^ r_hb_prev;
`else
  logic w_unused_heartbeat;
  assign w_unused_heartbeat = bus.heartbeat;
`endif

  always_ff @(posedge sys_clk or negedge usr_rstn) begin
    if (!usr_rstn) begin
      r_state      <= PULSE;
      r_stable_cnt <= '0;
      r_drop_cnt   <= '0;
      r_pulse_cnt  <= '0;
      r_sys_rst    <= 1'b1;
      r_stdy_rst   <= 1'b1;
      r_ready      <= 1'b0;
      r_lost_cnt   <= '0;
`ifdef SERVANT_RST_WDT_EN
      r_wdt_cnt    <= '0;
      r_hb_prev    <= 1'b0;
`endif
    end else begin
      // Drop and watchdog counters only live in RUN; everywhere else they idle at 0.
      r_drop_cnt <= '0;
`ifdef SERVANT_RST_WDT_EN
      r_wdt_cnt  <= '0;
      r_hb_prev  <= w_hb_s;
`endif
      case (r_state)
        PULSE: begin
          r_sys_rst  <= 1'b1;
          r_stdy_rst <= 1'b1;
          r_ready    <= 1'b0;
          if (r_pulse_cnt == PLS_LAST) begin
            r_pulse_cnt <= '0;
            r_stdy_rst  <= 1'b0;
            r_state     <= WAIT_LOCK;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + PLS_W'(1);
          end
        end

        WAIT_LOCK: begin
          r_sys_rst  <= 1'b1;
          r_stdy_rst <= 1'b0;
          r_ready    <= 1'b0;
          if (w_lock_s) begin
            r_stable_cnt <= '0;
            r_state      <= STABLE;
          end
        end

        STABLE: begin
          // Unfiltered: any low sample restarts the qualification window.
          // The counter climbs to STABLE_CYCLES and release happens on the
          // next high sample, so it never needs to count past its maximum.
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
          end else if (r_stable_cnt == STB_MAX) begin
            r_stable_cnt <= '0;
            r_sys_rst    <= 1'b0;
            r_ready      <= 1'b1;
            r_state      <= RUN;
          end else begin
            r_stable_cnt <= r_stable_cnt + STB_W'(1);
          end
        end

        RUN: begin
          // Lock loss is evaluated first so it wins over a same-cycle timeout.
          if (!w_lock_s && (r_drop_cnt == DRP_LAST)) begin
            r_lost_cnt  <= lost_sat_inc(r_lost_cnt);
            r_sys_rst   <= 1'b1;
            r_stdy_rst  <= 1'b1;
            r_ready     <= 1'b0;
            r_pulse_cnt <= '0;
            r_state     <= PULSE;
          end else begin
            if (!w_lock_s) begin
              r_drop_cnt <= r_drop_cnt + DRP_W'(1);
            end
`ifdef SERVANT_RST_WDT_EN
            if (w_hb_edge) begin
              r_wdt_cnt <= '0;
            end else if (r_wdt_cnt == WDT_LAST) begin
              r_sys_rst   <= 1'b1;
              r_stdy_rst  <= 1'b1;
              r_ready     <= 1'b0;
              r_pulse_cnt <= '0;
              r_state     <= PULSE;
            end else begin
              r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
            end
`endif
          end
        end

        default: r_state <= PULSE;
      endcase
    end
  end

  assign bus.sys_rst   = r_sys_rst;
  assign bus.sys_rst_n = ~r_sys_rst;
  assign bus.stdy_rst  = r_stdy_rst;
  assign bus.ready     = r_ready;
  assign bus.lost_cnt  = r_lost_cnt;

endmodule

// File: tb/tb_servant_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_servant_rst_seq
// Directed stimulus pushes every expected output change (cycle + value of
// {sys_rst, sys_rst_n, stdy_rst, ready, lost_cnt}) into a queue; a monitor pops
// one entry whenever the outputs change and compares value and cycle.
// Build with SERVANT_RST_WDT_EN to also exercise the heartbeat watchdog.
// -----------------------------------------------------------------------------
module tb_servant_rst_seq;

  localparam int STABLE = 16;
  localparam int DROP   = 4;
  localparam int STDY   = 8;
  localparam int WDT    = 100;

  typedef struct {
    string      name;
    int         cyc;
    logic [11:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic usr_rstn;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  servant_rst_seq_if bus_if();

  servant_rst_seq #(
    .STABLE_CYCLES   (STABLE),
    .DROP_FILTER     (DROP),
    .STDY_RST_CYCLES (STDY),
    .WDT_CYCLES      (WDT)
  ) dut (
    .sys_clk  (clk),
    .usr_rstn (usr_rstn),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs at cycle c (c < 0: cycle not checked).
  task automatic push(input string nm, input int c, input logic rst, input logic stdy,
                      input logic rdy, input logic [7:0] lost);
    exp_t e;
    e.name = nm;
    e.cyc  = c;
    e.vec  = {rst, ~rst, stdy, rdy, lost};
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Release reset with lock already high: stdy_rst ends after 8 cycles, one
  // WAIT_LOCK edge, 16 counting edges plus the release edge -> 26.
  task automatic release_rst();
    int r;
    usr_rstn = 1'b1;
    r = cyc;
    push("rel_stdy_end", r + 8,  1'b1, 1'b0, 1'b0, 8'd0);
    push("rel_run",      r + 26, 1'b0, 1'b0, 1'b1, 8'd0);
    wait_cyc(r + 26);
  endtask

  // Monitor: one comparison per observed output change.
  logic [11:0] mon_last = 'x;
  logic [11:0] mon_cur;
  exp_t        mon_e;
  initial begin
    forever begin
      @(negedge clk);
      mon_cur = {bus_if.sys_rst, bus_if.sys_rst_n, bus_if.stdy_rst, bus_if.ready, bus_if.lost_cnt};
      if (mon_cur !== mon_last) begin
        mon_last = mon_cur;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change: got out=%h at cyc %0d, required no change", mon_cur, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if ((mon_cur !== mon_e.vec) || ((mon_e.cyc >= 0) && (mon_e.cyc != cyc))) begin
            n_err++;
            $display("FAIL %s: got out=%h at cyc %0d, required out=%h at cyc %0d",
                     mon_e.name, mon_cur, cyc, mon_e.vec, mon_e.cyc);
          end else begin
            $display("ok   %s: out=%h cyc=%0d", mon_e.name, mon_cur, cyc);
          end
        end
      end
    end
  end

  initial begin
    int d;
    int h;
    int r;
    int t;
    logic [7:0] lost;

    usr_rstn         = 1'b0;
    bus_if.pll_lock  = 1'b1;
    bus_if.heartbeat = 1'b0;
    push("reset_values", -1, 1'b1, 1'b1, 1'b0, 8'd0);
    wait_neg(3);

    // 1) Power-up with lock tied high.
    release_rst();
    wait_neg(2);

    // 2) Three-cycle lock glitch in RUN: filtered, no output change.
    bus_if.pll_lock = 1'b0;
    wait_neg(3);
    bus_if.pll_lock = 1'b1;
    wait_neg(10);

    // 3) Real loss (accepted 2 sync + 4 filter cycles later), then lock
    //    toggling with period 10, then steady lock.
    d = cyc;
    bus_if.pll_lock = 1'b0;
    push("loss_accept",   d + 6,  1'b1, 1'b1, 1'b0, 8'd1);
    push("loss_stdy_end", d + 14, 1'b1, 1'b0, 1'b0, 8'd1);
    wait_neg(6);
    for (int k = 0; k < 4; k++) begin
      bus_if.pll_lock = 1'b1;
      wait_neg(5);
      bus_if.pll_lock = 1'b0;
      wait_neg(5);
    end
    bus_if.pll_lock = 1'b1;
    h = cyc;
    // Seen high 3 edges later -> STABLE, then 17 more edges to RUN.
    push("toggle_then_run", h + 20, 1'b0, 1'b0, 1'b1, 8'd1);
    wait_cyc(h + 20);
    wait_neg(2);

    // 4a) usr_rstn dropped mid-RUN between clock edges.
    @(posedge clk);
    #2;
    usr_rstn = 1'b0;
    push("async_rst_run", cyc, 1'b1, 1'b1, 1'b0, 8'd0);
    wait_neg(3);
    usr_rstn = 1'b1;
    r = cyc;
    push("rel2_stdy_end", r + 8, 1'b1, 1'b0, 1'b0, 8'd0);
    wait_cyc(r + 14);
    // 4b) usr_rstn dropped mid-STABLE (stdy_rst rises with no clock edge).
    @(posedge clk);
    #2;
    usr_rstn = 1'b0;
    push("async_rst_stable", cyc, 1'b1, 1'b1, 1'b0, 8'd0);
    wait_neg(3);
    release_rst();

`ifdef SERVANT_RST_WDT_EN
    // 5) Watchdog: constant heartbeat from RUN entry times out at +100.
    d = cyc;
    push("wdt_timeout",   d + 100, 1'b1, 1'b1, 1'b0, 8'd0);
    push("wdt_stdy_end",  d + 108, 1'b1, 1'b0, 1'b0, 8'd0);
    push("wdt_run",       d + 126, 1'b0, 1'b0, 1'b1, 8'd0);
    wait_cyc(d + 126);
    // Toggling every 50 cycles keeps it alive.
    for (int k = 0; k < 8; k++) begin
      wait_neg(50);
      bus_if.heartbeat = ~bus_if.heartbeat;
    end
    t = cyc;
    // Edge reaches the detector 3 edges later, then 100 quiet cycles.
    push("wdt_timeout2",  t + 103, 1'b1, 1'b1, 1'b0, 8'd0);
    push("wdt_stdy_end2", t + 111, 1'b1, 1'b0, 1'b0, 8'd0);
    push("wdt_run2",      t + 129, 1'b0, 1'b0, 1'b1, 8'd0);
    wait_cyc(t + 129);
`endif

    // 6) 300 accepted losses: lost_cnt saturates at 255.
    for (int n = 1; n <= 300; n++) begin
      lost = (n > 255) ? 8'd255 : 8'(n);
      d = cyc;
      bus_if.pll_lock = 1'b0;
      push("sat_accept",   d + 6,  1'b1, 1'b1, 1'b0, lost);
      push("sat_stdy_end", d + 14, 1'b1, 1'b0, 1'b0, lost);
      push("sat_run",      d + 32, 1'b0, 1'b0, 1'b1, lost);
      wait_neg(6);
      bus_if.pll_lock = 1'b1;
      wait_cyc(d + 32);
    end

    wait_neg(10);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_events: got %0d expected changes never seen, required 0 (next: %s at cyc %0d)",
               exp_q.size(), exp_q[0].name, exp_q[0].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/servant_rst_seq.md
Name: servant_rst_seq

Overview:
- Reset sequencer between the CC_PLL / CC_USR_RSTN primitives and the servant SoC on the GateMate board tops.
- Synchronises the PLL lock flag and holds the SoC in reset until lock has stayed stable for a programmable time.
- Filters lock glitches and re-sequences after a real loss of lock.
- Counts loss-of-lock events for debug and optionally runs a heartbeat watchdog.

Parameters:
- STABLE_CYCLES, 16, cycles lock must be continuously high before reset release (≥1).
- DROP_FILTER, 4, consecutive synchronised-low cycles before lock loss is accepted (≥1).
- STDY_RST_CYCLES, 8, pulse width of stdy_rst at the start of every sequence (≥1).
- WDT_CYCLES, 16777216, watchdog timeout in cycles (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock (PLL CLK0).
- usr_rstn  in  1  asynchronous active-low reset (from CC_USR_RSTN).
- pll_lock  in  1  PLL locked flag, asynchronous to sys_clk.
- heartbeat  in  1  SoC activity signal, e.g. GPIO q; any edge counts.
- sys_rst  out  1  active-high SoC reset.
- sys_rst_n  out  1  exact complement of sys_rst.
- stdy_rst  out  1  drives USR_LOCKED_STDY_RST.
- ready  out  1  high only in RUN.
- lost_cnt  out  8  saturating count of accepted lock losses.

Behaviour:
- Reset is asynchronous, active-low; all flops clear on usr_rstn=0. Deassertion takes effect on the next sys_clk edge.
- Values held while in reset: sys_rst=1, sys_rst_n=0, stdy_rst=1, ready=0, lost_cnt=0, state=PULSE, counters=0.
- pll_lock passes through a 2-flop synchroniser, giving lock_s; all decisions use lock_s. Latency from pll_lock to lock_s is 2 cycles.
- State PULSE:
  - stdy_rst=1 and sys_rst=1 for STDY_RST_CYCLES cycles.
  - Then go to WAIT_LOCK.
- State WAIT_LOCK:
  - stdy_rst=0, sys_rst=1.
  - Stay while lock_s=0.
  - When lock_s=1, clear the stable counter and go to STABLE.
- State STABLE:
  - sys_rst=1. The counter increments each cycle lock_s=1.
  - If lock_s=0 in any cycle, return to WAIT_LOCK immediately. No filter applies here, and lost_cnt is not incremented.
  - After STABLE_CYCLES consecutive high cycles, go to RUN.
  - sys_rst falls on the same clock edge that enters RUN.
- State RUN:
  - sys_rst=0, sys_rst_n=1, ready=1.
  - The drop counter increments while lock_s=0 and clears whenever lock_s=1.
  - When the drop counter reaches DROP_FILTER: increment lost_cnt (saturates at 255, no wrap), assert sys_rst on that edge, and go to PULSE.
  - A low glitch shorter than DROP_FILTER cycles has no effect.
- Simultaneous events: if a lock-loss acceptance and a watchdog timeout occur in the same cycle, lock loss takes priority. lost_cnt increments once, and the watchdog event is discarded.
- Counter widths are $clog2(parameter+1). No counter may wrap in any state.
- Reset mid-sequence: usr_rstn low in any state returns to PULSE with all outputs at reset values. lost_cnt is also cleared.
- sys_rst and sys_rst_n are registered outputs, with no combinational path from inputs.

Optional Feature:
- Macro: SERVANT_RST_WDT_EN.
- With the macro defined:
  - heartbeat passes through a 2-flop synchroniser; an edge detector finds changes.
  - In RUN, a watchdog counter counts cycles since the last heartbeat edge and clears on every edge.
  - On reaching WDT_CYCLES, go to PULSE. sys_rst asserts on that edge; lost_cnt is not incremented.
  - The watchdog counter is cleared outside RUN.
- Without the macro: heartbeat is ignored (port kept, unused), and the watchdog logic is not synthesised.

Decomposition:
- Package servant_rst_pkg holds the state enum (PULSE, WAIT_LOCK, STABLE, RUN; 2-bit encoding) and LOST_CNT_W=8.
- Sub-module servant_sync2: a parameterised-width 2-flop synchroniser with async active-low clear. It is used for pll_lock and for heartbeat.

Test Plan:
- Reset release with pll_lock tied 1 → stdy_rst high for 8 cycles after usr_rstn rises. sys_rst falls at 8+2+1+16 cycles (±1 for the sync edge), after which ready=1 and lost_cnt=0.
- pll_lock low for 3 cycles in RUN (DROP_FILTER=4) → sys_rst stays 0 and lost_cnt stays 0. Low for 4+ cycles → sys_rst=1, stdy_rst pulses 8 cycles, and lost_cnt=1.
- pll_lock toggling with a period of 10 cycles during STABLE → sys_rst never deasserts and lost_cnt=0. Then holding lock high → release after 16 stable cycles.
- 300 accepted lock losses → lost_cnt saturates at 255.
- usr_rstn pulsed low mid-STABLE and mid-RUN → outputs go to reset values asynchronously, with no clock edge required.
- With SERVANT_RST_WDT_EN and WDT_CYCLES=100: heartbeat held constant in RUN → reset at cycle 100 with lost_cnt unchanged. heartbeat toggled every 50 cycles → no reset.
